cdb_arbiter: RTL
================

# cdb_arbiter

- Shares the 4-slot common data bus (CDB) among `NUM_FU` functional-unit result ports.
- Each FU result is buffered in a per-FU 2-entry FIFO. Every cycle, up to 4 FIFO heads are granted in round-robin order and driven onto the registered CDB outputs.
- The CDB outputs feed every reservation station and the ROB directly, using the flat packing those blocks already consume.

## Interface
Parameters:
- `NUM_FU`, default 6 – number of functional-unit result ports; legal range 4..8.

Ports:
- `clk`  in  1  – single clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  – synchronous, active-high reset.
- `fu_valid`  in  NUM_FU  – bit j: FU j presents a result this cycle.
- `fu_rob_index_flat`  in  4*NUM_FU  – FU j's ROB index at bits [4j+3:4j].
- `fu_result_flat`  in  16*NUM_FU  – FU j's result at bits [16j+15:16j].
- `fu_ready`  out  NUM_FU  – bit j: FU j's FIFO can accept this cycle.
- `cdb_valid_flat`  out  4  – slot k valid at bit [3-k].
- `cdb_rob_index_flat`  out  16  – slot k ROB index at bits [4(3-k)+3:4(3-k)].
- `cdb_result_flat`  out  64  – slot k result at bits [16(3-k)+15:16(3-k)].

## Operation
Push:
- FU j is accepted on a rising edge where `fu_valid[j] & fu_ready[j]`.
- `fu_ready[j]` = FIFO j occupancy < 2, computed from registered state only. A FIFO holding 2 entries is not ready, even if it is popped in the same cycle.
- `fu_valid[j]` while not ready: the data is ignored. The FU must hold its data and retry.

Eligibility:
- FU j is eligible when its FIFO is non-empty, counted at the start of the cycle.
- There is no bypass: an entry pushed at edge E is first eligible in the cycle after E.

Grant:
- Scan FUs in order ptr, ptr+1, …, wrapping mod NUM_FU.
- The first up to 4 eligible FUs are granted. The n-th granted FU (n = 0..3) takes CDB slot n.
- At most one entry is popped per FIFO per cycle.

Round-robin pointer `ptr`:
- If at least one grant: `ptr` <= (index of last granted FU + 1) mod NUM_FU.
- If no grants: unchanged.

CDB outputs (registered):
- Granted slots: valid = 1, with the head entry's ROB index and result.
- Ungranted slots: valid = 0, ROB index = 0, result = 0.
- The CDB carries no backpressure. Every consumer must capture the bus in the cycle it is valid.

FIFO ordering:
- Each FIFO is first-in first-out.
- Results from one FU appear on the CDB in acceptance order.
- No ordering is guaranteed across FUs.

Reset (`rst` high at an edge):
- All FIFOs emptied; `ptr` = 0.
- All CDB outputs = 0.
- Any in-flight push or grant in that cycle is discarded.
- `fu_ready` is forced to 0 combinationally while `rst` is high. It returns to all-ones in the first cycle after `rst` deasserts.

## Timing
- Latency: a result accepted at edge E is driven on the CDB at edge E+1 at the earliest, and is visible during cycle E+1..E+2.
- Throughput: up to 4 results per cycle aggregate; up to 1 result per cycle per FU sustained.
- Simultaneous push and pop on the same FIFO (occupancy 1): occupancy stays 1, and the pushed entry becomes the new head.
- More than 4 eligible FUs: excess FUs keep their entries. The `ptr` advance guarantees they are granted within ceil(NUM_FU/4) cycles.
- Pointer wrap: the scan from `ptr` = NUM_FU-1 continues at FU 0.
- Outputs after reset: `cdb_valid_flat` = 4'b0000, `cdb_rob_index_flat` = 0, `cdb_result_flat` = 0, `fu_ready` = all ones.

## Structure
- Shared package `cdb_pkg` holds:
  - `CDB_SLOTS` = 4, `ROB_IDX_W` = 4, `DATA_W` = 16;
  - the slot-to-bit packing helper functions, used by this block and by all CDB consumers.
- Sub-module `cdb_fu_fifo`: 2-entry FIFO with push/pop, count, and head outputs; one instance per FU.
- Top level contains:
  - the rotating-priority selection (combinational over NUM_FU, 4 passes);
  - the `ptr` register;
  - the CDB output registers.

## Test plan
- **Reset:** hold `rst` 2 cycles with all `fu_valid` = 1 → `fu_ready` = 0 during reset, CDB all zero. The first post-reset cycle gives `fu_ready` = all ones and nothing on the CDB.
- **Single result:** FU 2 pushes rob 4'h5 / 16'hBEEF at edge E → at edge E+1, `cdb_valid_flat` = 4'b1000, slot 0 = (5, BEEF); `ptr` = 3.
- **Oversubscription:**
  - Setup: all 6 FUs push once at edge E with `ptr` = 0 (rob = j, result = 16'h1000+j).
  - Edge E+1: slots 0..3 carry FUs 0..3 and `ptr` = 4.
  - Edge E+2: slots 0..1 carry FUs 4,5, slots 2..3 invalid, and `ptr` = 0.
- **Per-FU backpressure:** FU 1 pushes on 3 consecutive cycles while FUs 2..5 keep 4 slots busy → `fu_ready[1]` drops after 2 accepted pushes. The third value is accepted only after a pop, and FU 1's results appear in push order.
- **Wrap-around:** with `ptr` = 5, FUs 5, 0, 1 eligible → slot 0 = FU 5, slot 1 = FU 0, slot 2 = FU 1, slot 3 invalid; `ptr` = 2.
- **Mid-operation reset:** assert `rst` while 3 FIFOs hold entries → next cycle CDB = 0, no held entry ever appears, and `ptr` = 0.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared CDB definitions: slot count, field widths, entry type and slot packing helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a; the CDB itself carries none, consumers capture every valid slot.
package cdb_pkg;

  localparam int CDB_SLOTS = 4;
  localparam int ROB_IDX_W = 4;
  localparam int DATA_W    = 16;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [DATA_W-1:0]    cdb_data_t;

  typedef struct packed {
    rob_idx_t  rob_idx;
    cdb_data_t result;
  } cdb_entry_t;

  // Ascending packed ranges put slot 0 in the most significant position, so a
  // vector of these types has exactly the bit layout of the flat CDB buses.
  typedef logic [0:CDB_SLOTS-1]                cdb_vld_vec_t;
  typedef logic [0:CDB_SLOTS-1][ROB_IDX_W-1:0] cdb_rob_vec_t;
  typedef logic [0:CDB_SLOTS-1][DATA_W-1:0]    cdb_res_vec_t;

  // Lowest bit of slot `slot` in a flat bus whose fields are `width` bits wide.
  function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned width);
    return width * (CDB_SLOTS - 1 - slot);
  endfunction

  function automatic logic [CDB_SLOTS-1:0] pack_vld(input cdb_vld_vec_t v);
    return v;
  endfunction

  function automatic logic [CDB_SLOTS*ROB_IDX_W-1:0] pack_rob(input cdb_rob_vec_t v);
    return v;
  endfunction

  function automatic logic [CDB_SLOTS*DATA_W-1:0] pack_res(input cdb_res_vec_t v);
    return v;
  endfunction

endpackage

// File: rtl/cdb_fu_fifo.sv
// Two-entry result FIFO for one functional unit.
// Latency: an entry pushed at edge E appears at the head from cycle E+1 (no bypass).
// Backpressure: pushes while full are dropped; the caller gates push with count < 2.
// Ports: clk/rst; push + push_rob/push_res in; pop in; count, head_rob/head_res out.
module cdb_fu_fifo
  import cdb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rob_idx_t   push_rob,
  input  cdb_data_t  push_res,
  input  logic       pop,
  output logic [1:0] count,
  output rob_idx_t   head_rob,
  output cdb_data_t  head_res
);

  cdb_entry_t mem_q [2];
  cdb_entry_t mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign do_push = push & (count_q != 2'd2);
  assign do_pop  = pop  & (count_q != 2'd0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = '{rob_idx: push_rob, result: push_res};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only observed once count says it exists.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count    = count_q;
  assign head_rob = mem_q[rd_ptr_q].rob_idx;
  assign head_res = mem_q[rd_ptr_q].result;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the 4-slot CDB among NUM_FU result ports via per-FU FIFOs.
// Latency: result accepted at edge E is on the registered CDB at edge E+1 at the earliest.
// Backpressure: fu_ready[j] low while FIFO j is full or rst is high; the CDB has none.
// Ports: clk, rst; fu_valid/fu_rob_index_flat/fu_result_flat in, fu_ready out;
//        cdb_valid_flat/cdb_rob_index_flat/cdb_result_flat out (slot 0 in the MSBs).
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [ROB_IDX_W*NUM_FU-1:0]    fu_rob_index_flat,
  input  logic [DATA_W*NUM_FU-1:0]       fu_result_flat,
  output logic [NUM_FU-1:0]              fu_ready,
  output logic [CDB_SLOTS-1:0]           cdb_valid_flat,
  output logic [CDB_SLOTS*ROB_IDX_W-1:0] cdb_rob_index_flat,
  output logic [CDB_SLOTS*DATA_W-1:0]    cdb_result_flat
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] elig;
  logic [1:0]        count    [NUM_FU];
  rob_idx_t          head_rob [NUM_FU];
  cdb_data_t         head_res [NUM_FU];

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  cdb_vld_vec_t      cdb_valid_q, cdb_valid_d;
  cdb_rob_vec_t      cdb_rob_q, cdb_rob_d;
  cdb_res_vec_t      cdb_res_q, cdb_res_d;

  logic [PTR_W:0]    scan_sum;
  logic [PTR_W-1:0]  scan_idx;
  logic [2:0]        n_granted;

  for (genvar j = 0; j < NUM_FU; j++) begin : g_fu
    // Ready looks only at registered occupancy, so a full FIFO stays not-ready
    // even in a cycle where its head is being granted.
    assign fu_ready[j] = ~rst & (count[j] != 2'd2);
    assign push[j]     = fu_valid[j] & fu_ready[j];
    assign elig[j]     = (count[j] != 2'd0);

    cdb_fu_fifo u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[j]),
      .push_rob (fu_rob_index_flat[ROB_IDX_W*j +: ROB_IDX_W]),
      .push_res (fu_result_flat[DATA_W*j +: DATA_W]),
      .pop      (pop[j]),
      .count    (count[j]),
      .head_rob (head_rob[j]),
      .head_res (head_res[j])
    );
  end

  // Rotating-priority scan starting at ptr; the n-th eligible FU found takes
  // slot n until all slots are used. The pointer lands one past the last grant
  // so FUs skipped this cycle are first in line next cycle.
  always_comb begin
    pop         = '0;
    ptr_d       = ptr_q;
    cdb_valid_d = '0;
    cdb_rob_d   = '0;
    cdb_res_d   = '0;
    n_granted   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (scan_sum >= (PTR_W+1)'(NUM_FU)) begin
        scan_sum = scan_sum - (PTR_W+1)'(NUM_FU);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (elig[scan_idx] && (n_granted < 3'(CDB_SLOTS))) begin
        pop[scan_idx]                = 1'b1;
        cdb_valid_d[n_granted[1:0]]  = 1'b1;
        cdb_rob_d[n_granted[1:0]]    = head_rob[scan_idx];
        cdb_res_d[n_granted[1:0]]    = head_res[scan_idx];
        ptr_d     = (scan_idx == PTR_W'(NUM_FU - 1)) ? '0 : scan_idx + PTR_W'(1);
        n_granted = n_granted + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      cdb_valid_q <= '0;
      cdb_rob_q   <= '0;
      cdb_res_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_rob_q   <= cdb_rob_d;
      cdb_res_q   <= cdb_res_d;
    end
  end

  assign cdb_valid_flat     = pack_vld(cdb_valid_q);
  assign cdb_rob_index_flat = pack_rob(cdb_rob_q);
  assign cdb_result_flat    = pack_res(cdb_res_q);

endmodule
